hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 25 ++
 rtl/hazard_ctrl_thermo_mask.sv | 17 +
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
package hazard_ctrl_pkg;

  // Default pipeline depth; this is also the default StallBus width.
  localparam int STAGES_DEF = 6;
  localparam int STALL_W_DEF = STAGES_DEF;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    TSTALL = 2'd1,
    FLUSH  = 2'd2
  } hz_state_e;

  // Registered redirect issued to the front end.
  typedef struct packed {
    logic        flush;
    logic [31:0] pc;
  } redirect_t;

  // Width of one stage index; at least one bit for a single-stage pipe.
  function automatic int sw_of(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_thermo_mask.sv
// Stage index to thermometer freeze mask: bits [idx:0] set.
// Indices beyond the last stage naturally saturate to all-ones.
module thermo_mask #(
  parameter int STAGES = 6,
  parameter int SW     = 3
) (
  input  logic [SW-1:0]     idx,
  output logic [STAGES-1:0] mask
);

  // Stage i is frozen when it is at or below the requested index.
  always_comb begin
    mask = '0;
    for (int i = 0; i < STAGES; i++) mask[i] = (i <= int'(idx));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: merges combinational stall requests,
// sequences multi-cycle timed stalls and issues registered flush pulses.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int NREQ   = 4,
  parameter int CNT_W  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ*sw_of(STAGES)-1:0]  req_stage,
  input  logic                           timed_req,
  input  logic [sw_of(STAGES)-1:0]       timed_stage,
  input  logic [CNT_W-1:0]               timed_cycles,
  input  logic                           flush_req,
  input  logic [31:0]                    flush_pc,
  output logic [STAGES-1:0]              stall,
  output logic                           flush,
  output logic [31:0]                    new_pc,
  output logic                           busy,
  output logic [31:0]                    stall_cycles
);

  localparam int SW = sw_of(STAGES);

  hz_state_e                   state, state_nxt;
  logic [CNT_W-1:0]            cnt, cnt_nxt;
  logic [NREQ-1:0][STAGES-1:0] req_mask;
  logic [STAGES-1:0]           req_or, timed_mask, timed_mask_q, stall_raw;
  logic                        timed_acc;
  redirect_t                   redir_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    thermo_mask #(.STAGES(STAGES), .SW(SW)) u_mask (
      .idx  (req_stage[g*SW +: SW]),
      .mask (req_mask[g])
    );
  end

  thermo_mask #(.STAGES(STAGES), .SW(SW)) u_timed_mask (
    .idx  (timed_stage),
    .mask (timed_mask)
  );

  // OR of the masks of all valid requesters.
  always_comb begin
    req_or = '0;
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i]) req_or = req_or | req_mask[i];
  end

  // A timed stall is only taken from RUN, and a same-cycle flush drops it.
  assign timed_acc = (state == RUN) && timed_req && !flush_req &&
                     (timed_cycles != '0);

  // Next state and countdown. cnt holds the timed-stall cycles still owed
  // after the request cycle; the last TSTALL cycle is the one with cnt==1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (flush_req) begin
          state_nxt = FLUSH;
        end else if (timed_acc) begin
          cnt_nxt   = timed_cycles - CNT_W'(1);
          state_nxt = (timed_cycles == CNT_W'(1)) ? RUN : TSTALL;
        end
      end
      TSTALL: begin
        if (flush_req) begin
          state_nxt = FLUSH;
          cnt_nxt   = '0;
        end else if (cnt <= CNT_W'(1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      FLUSH:   state_nxt = flush_req ? FLUSH : RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Freeze vector: nothing is held in the redirect cycle or under reset.
  always_comb begin
    stall_raw = req_or;
    if (state == TSTALL) stall_raw = stall_raw | timed_mask_q;
    if (timed_acc)       stall_raw = stall_raw | timed_mask;
    if (state == FLUSH)  stall_raw = '0;
  end

  assign stall  = rst ? '0 : stall_raw;
  assign busy   = !rst && ((state == TSTALL) || timed_acc);
  assign flush  = redir_q.flush;
  assign new_pc = redir_q.pc;

  // State, countdown, latched timed mask and redirect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= '0;
      timed_mask_q <= '0;
      redir_q      <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      redir_q.flush <= (state_nxt == FLUSH);
      if (timed_acc) timed_mask_q <= timed_mask;
      if (flush_req) redir_q.pc   <= flush_pc;
    end
  end

  // Saturating count of cycles in which any stage was frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if ((stall != '0) && !(&stall_cycles))
      stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with default parameters.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [11:0] req_stage;
  logic        timed_req;
  logic [2:0]  timed_stage;
  logic [7:0]  timed_cycles;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
  logic [31:0] stall_cycles;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_stage    (req_stage),
    .timed_req    (timed_req),
    .timed_stage  (timed_stage),
    .timed_cycles (timed_cycles),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [11:0] st;
    logic        tr;
    logic [2:0]  ts;
    logic [7:0]  tc;
    logic        fr;
    logic [31:0] fpc;
    logic [5:0]  e_stall;
    logic        e_busy;
    logic        e_flush;
    logic [31:0] e_pc;
  } vec_t;

  vec_t        sb[$];
  vec_t        tbl[9];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_sc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive after the edge, compare at the falling edge.
  task automatic step(input vec_t t, input string name);
    vec_t e;
    @(posedge clk);
    #1;
    req_valid    = t.v;
    req_stage    = t.st;
    timed_req    = t.tr;
    timed_stage  = t.ts;
    timed_cycles = t.tc;
    flush_req    = t.fr;
    flush_pc     = t.fpc;
    sb.push_back(t);
    @(negedge clk);
    e = sb.pop_front();
    chk({name, ".stall"}, {26'd0, stall}, {26'd0, e.e_stall});
    chk({name, ".busy"},  {31'd0, busy},  {31'd0, e.e_busy});
    chk({name, ".flush"}, {31'd0, flush}, {31'd0, e.e_flush});
    if (e.e_flush) chk({name, ".new_pc"}, new_pc, e.e_pc);
    chk({name, ".stall_cycles"}, stall_cycles, exp_sc);
    if (e.e_stall != 6'd0) exp_sc = exp_sc + 1;
  endtask

  task automatic cyc(input logic [3:0] v, input logic [11:0] st, input logic tr,
                     input logic [2:0] ts, input logic [7:0] tc, input logic fr,
                     input logic [31:0] fpc, input logic [5:0] es, input logic eb,
                     input logic ef, input logic [31:0] ep, input string name);
    vec_t t;
    t = '{v, st, tr, ts, tc, fr, fpc, es, eb, ef, ep};
    step(t, name);
  endtask

  initial begin
    // Combinational merge of requesters while in RUN.
    tbl[0] = '{4'b0011, 12'b000_000_011_001, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 0};
    tbl[1] = '{4'b0000, 12'b000_000_000_000, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0};
    tbl[2] = '{4'b0001, 12'b000_000_000_000, 0, 0, 0, 0, 0, 6'b000001, 0, 0, 0};
    tbl[3] = '{4'b1000, 12'b101_000_000_000, 0, 0, 0, 0, 0, 6'b111111, 0, 0, 0};
    tbl[4] = '{4'b0100, 12'b000_111_000_000, 0, 0, 0, 0, 0, 6'b111111, 0, 0, 0};
    tbl[5] = '{4'b0010, 12'b000_000_110_000, 0, 0, 0, 0, 0, 6'b111111, 0, 0, 0};
    tbl[6] = '{4'b1111, 12'b000_010_001_000, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 0};
    tbl[7] = '{4'b0000, 12'b111_111_111_111, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0};
    tbl[8] = '{4'b0101, 12'b000_010_000_100, 0, 0, 0, 0, 0, 6'b011111, 0, 0, 0};

    // Reset with live requests: outputs must stay quiet.
    rst = 1'b1;
    req_valid = 4'hF; req_stage = 12'hFFF; timed_req = 1'b1; timed_stage = 3'd5;
    timed_cycles = 8'd4; flush_req = 1'b1; flush_pc = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #2;
    chk("rst.stall", {26'd0, stall}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.flush", {31'd0, flush}, 32'd0);
    chk("rst.new_pc", new_pc, 32'd0);
    chk("rst.stall_cycles", stall_cycles, 32'd0);
    req_valid = 0; req_stage = 0; timed_req = 0; timed_stage = 0;
    timed_cycles = 0; flush_req = 0; flush_pc = 0;
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 9; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Timed stall, 3 cycles on stage 2.
    cyc(0, 0, 1, 2, 3, 0, 0, 6'b000111, 1, 0, 0, "t3.c0");
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b000111, 1, 0, 0, "t3.c1");
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b000111, 1, 0, 0, "t3.c2");
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, "t3.c3");

    // Timed requests during TSTALL are ignored; requesters still merge.
    cyc(0, 0, 1, 1, 3, 0, 0, 6'b000011, 1, 0, 0, "ign.c0");
    cyc(4'b0001, 12'd4, 1, 4, 8, 0, 0, 6'b011111, 1, 0, 0, "ign.c1");
    cyc(0, 0, 1, 4, 8, 0, 0, 6'b000011, 1, 0, 0, "ign.c2");
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, "ign.c3");

    // Flush in cycle 2 of a 5-cycle timed stall.
    cyc(0, 0, 1, 3, 5, 0, 0, 6'b001111, 1, 0, 0, "tf.c0");
    cyc(0, 0, 0, 0, 0, 1, 32'hBFC00380, 6'b001111, 1, 0, 0, "tf.c1");
    cyc(4'b0001, 12'd2, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 32'hBFC00380, "tf.c2");
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, "tf.c3");
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, "tf.c4");

    // Flush and timed request together: flush wins.
    cyc(0, 0, 1, 5, 4, 1, 32'h12345678, 6'b000000, 0, 0, 0, "ft.c0");
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 32'h12345678, "ft.c1");
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, "ft.c2");

    // Back-to-back flushes.
    cyc(0, 0, 0, 0, 0, 1, 32'hAAAA0000, 6'b000000, 0, 0, 0, "bb.c0");
    cyc(0, 0, 0, 0, 0, 1, 32'h5555FFF0, 6'b000000, 0, 1, 32'hAAAA0000, "bb.c1");
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 32'h5555FFF0, "bb.c2");
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, "bb.c3");

    // Zero-length timed request is ignored; length one lasts one cycle.
    cyc(0, 0, 1, 5, 0, 0, 0, 6'b000000, 0, 0, 0, "z.c0");
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, "z.c1");
    cyc(0, 0, 1, 0, 1, 0, 0, 6'b000001, 1, 0, 0, "one.c0");
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, "one.c1");

    // Asynchronous reset in the middle of a long timed stall.
    cyc(0, 0, 1, 4, 10, 0, 0, 6'b011111, 1, 0, 0, "ar.c0");
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b011111, 1, 0, 0, "ar.c1");
    #2 rst = 1'b1;
    #1;
    chk("ar.stall", {26'd0, stall}, 32'd0);
    chk("ar.busy", {31'd0, busy}, 32'd0);
    chk("ar.stall_cycles", stall_cycles, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    exp_sc = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, "ar.c2");
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, "ar.c3");
    cyc(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, "ar.c4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
